// File: rtl/vx_tag_fill_ctrl_pkg.sv
// Shared definitions for the tag-store write sequencer: walk state encoding and sizing helpers.
// PERF_CTR_BITS may be overridden on the command line before this file is read.
`ifndef PERF_CTR_BITS
`define PERF_CTR_BITS 44
`endif

package vx_tag_fill_ctrl_pkg;

  localparam int PERF_CTR_BITS = `PERF_CTR_BITS;

  // Encoding is shared with the other bank controllers, so the values are pinned.
  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    FLUSH = 2'd2
  } fill_state_e;

  function automatic int lines_per_bank(input int cache_size, input int line_size,
                                        input int num_banks);
    return cache_size / (line_size * num_banks);
  endfunction

  function automatic int line_select_bits(input int lines);
    return (lines > 1) ? $clog2(lines) : 1;
  endfunction

endpackage

// File: rtl/vx_tag_fill_ctrl_line_walker.sv
// Line counter that steps through every line of a bank; shared with the data-store initialiser.
module vx_line_walker #(
  parameter int CTR_BITS = 2,
  parameter int LAST     = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_i,
  input  logic                step_i,
  output logic [CTR_BITS-1:0] ctr_o,
  output logic                last_o
);

  logic [CTR_BITS-1:0] ctr_q, ctr_d;

  assign last_o = (ctr_q == CTR_BITS'(LAST));
  assign ctr_o  = ctr_q;

  // Stepping off the last line returns to 0 so the next walk starts clean.
  always_comb begin
    ctr_d = ctr_q;
    if (start_i) begin
      ctr_d = '0;
    end else if (step_i) begin
      ctr_d = last_o ? '0 : ctr_q + CTR_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctr_q <= '0;
    end else begin
      ctr_q <= ctr_d;
    end
  end

endmodule

// File: rtl/vx_tag_fill_ctrl.sv
// Tag-store write sequencer for one cache bank: merges line fills with reset/flush walks.
// Optional feature macro: TAG_FILL_PERF_EN adds fill/flush performance counters.
module vx_tag_fill_ctrl
  import vx_tag_fill_ctrl_pkg::*;
#(
  parameter int CACHE_ID         = 0,
  parameter int BANK_ID          = 0,
  parameter int CACHE_SIZE       = 1,
  parameter int CACHE_LINE_SIZE  = 1,
  parameter int NUM_BANKS        = 1,
  parameter int WORD_SIZE        = 1,
  parameter int BANK_ADDR_OFFSET = 0,
  parameter int FLUSH_ON_RESET   = 1,
  parameter int LINE_ADDR_WIDTH  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fill_req_valid,
  input  logic [LINE_ADDR_WIDTH-1:0] fill_req_addr,
  output logic                       fill_req_ready,
  input  logic                       flush_req_valid,
  output logic                       flush_req_ready,
  output logic                       flush_done,
  output logic                       tag_fill,
  output logic                       tag_is_flush,
  output logic [LINE_ADDR_WIDTH-1:0] tag_addr,
  output logic                       busy
`ifdef TAG_FILL_PERF_EN
  ,
  output logic [PERF_CTR_BITS-1:0]   perf_fills,
  output logic [PERF_CTR_BITS-1:0]   perf_flushes
`endif
);

  localparam int LINES_PER_BANK   = lines_per_bank(CACHE_SIZE, CACHE_LINE_SIZE, NUM_BANKS);
  localparam int LINE_SELECT_BITS = line_select_bits(LINES_PER_BANK);

  if ((LINES_PER_BANK < 1) || ((LINES_PER_BANK & (LINES_PER_BANK - 1)) != 0) ||
      (CACHE_LINE_SIZE < WORD_SIZE) || (BANK_ID >= NUM_BANKS) || (BANK_ADDR_OFFSET < 0) ||
      (LINE_ADDR_WIDTH < LINE_SELECT_BITS)) begin : g_cfg_err
    $error("vx_tag_fill_ctrl cache %0d bank %0d: unsupported geometry", CACHE_ID, BANK_ID);
  end

  fill_state_e                state_q, state_d;
  logic                       tag_fill_q, tag_fill_d;
  logic                       tag_is_flush_q, tag_is_flush_d;
  logic [LINE_ADDR_WIDTH-1:0] tag_addr_q, tag_addr_d;
  logic                       flush_done_q, flush_done_d;
  logic                       walk_start, walk_step, walk_last;
  logic [LINE_SELECT_BITS-1:0] walk_ctr;

  vx_line_walker #(
    .CTR_BITS (LINE_SELECT_BITS),
    .LAST     (LINES_PER_BANK - 1)
  ) u_walker (
    .clk     (clk),
    .reset   (reset),
    .start_i (walk_start),
    .step_i  (walk_step),
    .ctr_o   (walk_ctr),
    .last_o  (walk_last)
  );

  // Fills win over flushes in IDLE; a walk writes one invalidate per cycle until the last line.
  always_comb begin
    state_d         = state_q;
    tag_fill_d      = 1'b0;
    tag_is_flush_d  = 1'b0;
    tag_addr_d      = tag_addr_q;
    flush_done_d    = 1'b0;
    walk_start      = 1'b0;
    walk_step       = 1'b0;
    fill_req_ready  = (state_q == IDLE);
    flush_req_ready = (state_q == IDLE) && !fill_req_valid;
    case (state_q)
      IDLE: begin
        if (fill_req_valid) begin
          tag_fill_d = 1'b1;
          tag_addr_d = fill_req_addr;
        end else if (flush_req_valid) begin
          state_d    = FLUSH;
          walk_start = 1'b1;
        end
      end
      INIT, FLUSH: begin
        tag_fill_d     = 1'b1;
        tag_is_flush_d = 1'b1;
        tag_addr_d     = LINE_ADDR_WIDTH'(walk_ctr);
        walk_step      = 1'b1;
        if (walk_last) begin
          state_d      = IDLE;
          flush_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= (FLUSH_ON_RESET != 0) ? INIT : IDLE;
      tag_fill_q     <= 1'b0;
      tag_is_flush_q <= 1'b0;
      tag_addr_q     <= '0;
      flush_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      tag_fill_q     <= tag_fill_d;
      tag_is_flush_q <= tag_is_flush_d;
      tag_addr_q     <= tag_addr_d;
      flush_done_q   <= flush_done_d;
    end
  end

  assign tag_fill     = tag_fill_q;
  assign tag_is_flush = tag_is_flush_q;
  assign tag_addr     = tag_addr_q;
  assign flush_done   = flush_done_q;
  assign busy         = (state_q != IDLE);

`ifdef TAG_FILL_PERF_EN
  // The reset walk is not a requested flush, so only handshakes are counted.
  logic [PERF_CTR_BITS-1:0] perf_fills_q, perf_flushes_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fills_q   <= '0;
      perf_flushes_q <= '0;
    end else begin
      if (fill_req_valid && fill_req_ready) begin
        perf_fills_q <= perf_fills_q + PERF_CTR_BITS'(1);
      end
      if (flush_req_valid && flush_req_ready) begin
        perf_flushes_q <= perf_flushes_q + PERF_CTR_BITS'(1);
      end
    end
  end

  assign perf_fills   = perf_fills_q;
  assign perf_flushes = perf_flushes_q;
`endif

endmodule

// File: tb/tb_vx_tag_fill_ctrl.sv
// Self-checking bench for vx_tag_fill_ctrl: 4 lines per bank, 8-bit line address, flush on reset.
module tb_vx_tag_fill_ctrl;
  import vx_tag_fill_ctrl_pkg::*;

  localparam int AW = 8;
  localparam int NL = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          fill_req_valid = 1'b0;
  logic [AW-1:0] fill_req_addr = '0;
  logic          flush_req_valid = 1'b0;
  logic          fill_req_ready, flush_req_ready, flush_done;
  logic          tag_fill, tag_is_flush, busy;
  logic [AW-1:0] tag_addr;
`ifdef TAG_FILL_PERF_EN
  logic [PERF_CTR_BITS-1:0] perf_fills, perf_flushes;
`endif

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int            cyc;
    logic          is_flush;
    logic [AW-1:0] addr;
    logic          done;
  } wr_t;

  typedef struct {
    logic          fv;
    logic [AW-1:0] fa;
    logic          flv;
    logic          exp_fill_ready;
    logic          exp_flush_ready;
    logic          exp_busy;
    logic          push_fill;
    logic          push_walk;
  } vec_t;

  wr_t  sb[$];
  vec_t vecs[10];

  vx_tag_fill_ctrl #(
    .CACHE_ID         (0),
    .BANK_ID          (0),
    .CACHE_SIZE       (16),
    .CACHE_LINE_SIZE  (4),
    .NUM_BANKS        (1),
    .WORD_SIZE        (4),
    .BANK_ADDR_OFFSET (0),
    .FLUSH_ON_RESET   (1),
    .LINE_ADDR_WIDTH  (AW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .fill_req_valid  (fill_req_valid),
    .fill_req_addr   (fill_req_addr),
    .fill_req_ready  (fill_req_ready),
    .flush_req_valid (flush_req_valid),
    .flush_req_ready (flush_req_ready),
    .flush_done      (flush_done),
    .tag_fill        (tag_fill),
    .tag_is_flush    (tag_is_flush),
    .tag_addr        (tag_addr),
    .busy            (busy)
`ifdef TAG_FILL_PERF_EN
    ,
    .perf_fills      (perf_fills),
    .perf_flushes    (perf_flushes)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    fill_req_valid  = v.fv;
    fill_req_addr   = v.fa;
    flush_req_valid = v.flv;
  endtask

  task automatic pushFill(input int c, input logic [AW-1:0] a);
    sb.push_back('{cyc: c, is_flush: 1'b0, addr: a, done: 1'b0});
  endtask

  task automatic pushWalk(input int first);
    for (int i = 0; i < NL; i++) begin
      sb.push_back('{cyc: first + i, is_flush: 1'b1, addr: AW'(i), done: (i == NL - 1)});
    end
  endtask

  // Each cycle either the next expected write is due or the write port must be quiet.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checkOutput($sformatf("write@%0d{fill,flush,done,addr}", e.cyc),
                  {tag_fill, tag_is_flush, flush_done, tag_addr},
                  {1'b1, e.is_flush, e.done, e.addr});
    end else begin
      checkOutput($sformatf("quiet@%0d{fill,done}", cyc), {tag_fill, flush_done}, 2'b00);
    end
  end

  initial begin
    int c;
    int n;

    vecs[0] = '{1'b1, 8'h25, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    checkOutput("reset_regs", {tag_fill, tag_is_flush, flush_done, tag_addr}, '0);
    checkOutput("reset_busy_readys", {busy, fill_req_ready, flush_req_ready}, 3'b100);

    // Power-on walk: reset released in cycle c, invalidates land in c+1..c+4.
    reset = 1'b0;
    c = cyc;
    pushWalk(c + 1);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      checkOutput($sformatf("init_busy_k%0d", k), busy, (k < NL));
    end

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n = cyc;
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d{fill_rdy,flush_rdy,busy}", i),
                  {fill_req_ready, flush_req_ready, busy},
                  {vecs[i].exp_fill_ready, vecs[i].exp_flush_ready, vecs[i].exp_busy});
      if (vecs[i].push_fill) pushFill(n + 1, vecs[i].fa);
      if (vecs[i].push_walk) pushWalk(n + 2);
    end

`ifdef TAG_FILL_PERF_EN
    checkOutput("perf_fills", 64'(perf_fills), 64'd3);
    checkOutput("perf_flushes", 64'(perf_flushes), 64'd1);
`endif

    // Reset lands after line 1 of a flush: no done pulse, then a fresh walk from line 0.
    @(negedge clk);
    n = cyc;
    flush_req_valid = 1'b1;
    #1;
    checkOutput("midreset_flush_rdy", flush_req_ready, 1'b1);
    sb.push_back('{cyc: n + 2, is_flush: 1'b1, addr: 8'h00, done: 1'b0});
    sb.push_back('{cyc: n + 3, is_flush: 1'b1, addr: 8'h01, done: 1'b0});
    @(negedge clk);
    flush_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("midreset_regs", {tag_fill, tag_is_flush, flush_done, tag_addr}, '0);
    reset = 1'b0;
    c = cyc;
    pushWalk(c + 1);
    checkOutput("reinit_busy", busy, 1'b1);
    repeat (NL + 1) @(negedge clk);
    checkOutput("reinit_idle_busy", busy, 1'b0);
`ifdef TAG_FILL_PERF_EN
    checkOutput("perf_fills_after_reset", 64'(perf_fills), 64'd0);
    checkOutput("perf_flushes_after_reset", 64'(perf_flushes), 64'd0);
`endif

    repeat (2) @(negedge clk);
    checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
